// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks registers start_addr..end_addr (wrapping mod 2^ADDR_W)
// through a spare register-file read port and streams each word on valid/ready.
// Ports: clk, resetn (sync, active-high), start/start_addr/end_addr request,
// raddr/rdata read port, out_valid/out_ready/out_data/out_addr/out_last stream,
// busy/done status. Optional macro REGDUMP_CHECKSUM_EN appends an XOR checksum word.
module regfile_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE,
    S_CSUM
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;
`endif

  state_t state_q, state_d;

  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              olast_q, olast_d;
  logic              busy_q, busy_d;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  logic at_last;
  assign at_last = (cur_q == last_q);

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      oaddr_q <= '0;
      olast_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      olast_q <= olast_d;
      busy_q  <= busy_d;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    vld_d   = vld_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    olast_d = olast_q;
    busy_d  = busy_q;
`ifdef REGDUMP_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = start_addr;
          last_d  = end_addr;
          busy_d  = 1'b1;
          state_d = S_READ;
`ifdef REGDUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      S_READ: begin
        data_d  = rdata;
        oaddr_d = cur_q;
        vld_d   = 1'b1;
        state_d = S_SEND;
`ifdef REGDUMP_CHECKSUM_EN
        olast_d = 1'b0;
        acc_d   = acc_q ^ rdata;
`else
        olast_d = at_last;
`endif
      end
      S_SEND: begin
        if (out_ready) begin
          vld_d = 1'b0;
          if (at_last) begin
`ifdef REGDUMP_CHECKSUM_EN
            // Checksum word is loaded on the final data handshake so it
            // is valid in the very next cycle.
            vld_d   = 1'b1;
            data_d  = acc_q;
            oaddr_d = '0;
            olast_d = 1'b1;
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_CSUM: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The read port is only driven during READ so idle cycles leave it quiet.
  assign raddr     = (state_q == S_READ) ? cur_q : '0;
  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_addr  = oaddr_q;
  assign out_last  = olast_q;
  assign busy      = busy_q;
  assign done      = (state_q == S_DONE);

endmodule
